// File: rtl/forwarding_unit_pkg.sv
// Shared pipeline definitions for the EX-stage forwarding logic:
// operand-mux select codes and the architectural register index width.
package forwarding_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

endpackage : forwarding_unit_pkg

// File: rtl/forwarding_unit_fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight producer of rs,
// ignoring x0 and stages that do not write the register file.
module fwd_select
  import forwarding_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [ADDR_W-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic [1:0]        sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign mem_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = FWD_REGFILE;
    if (ex_hit) begin
      sel = FWD_EXMEM;   // EX/MEM holds the most recent value of rs
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule : fwd_select

// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding unit: combinational ALU operand selects plus
// saturating counters of cycles that forwarded from EX/MEM and from MEM/WB.
module forwarding_unit #(
  parameter int unsigned REG_ADDR_W = forwarding_unit_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rs1,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rs2,
  input  logic [REG_ADDR_W-1:0] EX_MEM_Rd,
  input  logic [REG_ADDR_W-1:0] MEM_WB_Rd,
  input  logic                  EX_MEM_regWrite,
  input  logic                  MEM_WB_regWrite,
  output logic [1:0]            Forward_A,
  output logic [1:0]            Forward_B,
  output logic [CNT_W-1:0]      fwd_ex_count,
  output logic [CNT_W-1:0]      fwd_mem_count
);

  import forwarding_unit_pkg::*;

  logic any_ex_fwd;
  logic any_mem_fwd;

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs               (ID_EX_Rs1),
    .ex_mem_rd        (EX_MEM_Rd),
    .ex_mem_reg_write (EX_MEM_regWrite),
    .mem_wb_rd        (MEM_WB_Rd),
    .mem_wb_reg_write (MEM_WB_regWrite),
    .sel              (Forward_A)
  );

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs               (ID_EX_Rs2),
    .ex_mem_rd        (EX_MEM_Rd),
    .ex_mem_reg_write (EX_MEM_regWrite),
    .mem_wb_rd        (MEM_WB_Rd),
    .mem_wb_reg_write (MEM_WB_regWrite),
    .sel              (Forward_B)
  );

  assign any_ex_fwd  = (Forward_A == FWD_EXMEM) || (Forward_B == FWD_EXMEM);
  assign any_mem_fwd = (Forward_A == FWD_MEMWB) || (Forward_B == FWD_MEMWB);

  // Counters stick at all-ones so a long run never reads back as a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking for all clocked state so every reader sees pre-edge values.
      fwd_ex_count  <= '0;
      fwd_mem_count <= '0;
    end else begin
      if (any_ex_fwd && (fwd_ex_count != {CNT_W{1'b1}})) begin
        fwd_ex_count <= fwd_ex_count + 1'b1;
      end
      if (any_mem_fwd && (fwd_mem_count != {CNT_W{1'b1}})) begin
        fwd_mem_count <= fwd_mem_count + 1'b1;
      end
    end
  end

endmodule : forwarding_unit

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed hazard vectors with literal
// expectations, plus a per-cycle comparison against a behavioural model.
module tb_forwarding_unit;

  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1, rs2, ex_rd, wb_rd;
  logic          ex_we, wb_we;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] ex_cnt, mem_cnt;

  int n_checks = 0;
  int n_passed = 0;
  bit model_on = 1'b0;
  int exp_ex   = 0;
  int exp_mem  = 0;

  forwarding_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_EX_Rs1       (rs1),
    .ID_EX_Rs2       (rs2),
    .EX_MEM_Rd       (ex_rd),
    .MEM_WB_Rd       (wb_rd),
    .EX_MEM_regWrite (ex_we),
    .MEM_WB_regWrite (wb_we),
    .Forward_A       (fwd_a),
    .Forward_B       (fwd_b),
    .fwd_ex_count    (ex_cnt),
    .fwd_mem_count   (mem_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Model: the operand comes from the youngest stage that writes that register;
  // x0 is hardwired and never comes from the pipeline.
  function automatic int model_sel(input int rs, input int erd, input bit ewe,
                                   input int wrd, input bit wwe);
    int  stage_rd [2];
    bit  stage_we [2];
    int  stage_code [2];
    stage_rd   = '{erd, wrd};
    stage_we   = '{ewe, wwe};
    stage_code = '{2, 1};
    if (rs == 0) return 0;
    foreach (stage_rd[i])
      if (stage_we[i] && stage_rd[i] == rs) return stage_code[i];
    return 0;
  endfunction

  function automatic int m_a();
    return model_sel(int'(rs1), int'(ex_rd), ex_we, int'(wb_rd), wb_we);
  endfunction

  function automatic int m_b();
    return model_sel(int'(rs2), int'(ex_rd), ex_we, int'(wb_rd), wb_we);
  endfunction

  // Model counters advance on the same edge as the DUT, from the inputs held there.
  always @(posedge clk) begin
    if (rst) begin
      exp_ex  = 0;
      exp_mem = 0;
    end else begin
      if (m_a() == 2 || m_b() == 2) exp_ex  = (exp_ex  < CMAX) ? exp_ex  + 1 : CMAX;
      if (m_a() == 1 || m_b() == 1) exp_mem = (exp_mem < CMAX) ? exp_mem + 1 : CMAX;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model Forward_A", int'(fwd_a), m_a());
      check("model Forward_B", int'(fwd_b), m_b());
      check("model fwd_ex_count", int'(ex_cnt), exp_ex);
      check("model fwd_mem_count", int'(mem_cnt), exp_mem);
    end
  end

  task automatic set_in(input int r1, input int r2, input int erd, input bit ewe,
                        input int wrd, input bit wwe);
    rs1   = AW'(r1);
    rs2   = AW'(r2);
    ex_rd = AW'(erd);
    ex_we = ewe;
    wb_rd = AW'(wrd);
    wb_we = wwe;
  endtask

  // Apply one vector for exactly one clock edge, checking selects before the
  // edge and both counters after it against hand-computed values.
  task automatic step(input string name, input int r1, input int r2, input int erd,
                      input bit ewe, input int wrd, input bit wwe,
                      input int ea, input int eb, input int ecx, input int ecm);
    set_in(r1, r2, erd, ewe, wrd, wwe);
    #1;
    check({name, " A"}, int'(fwd_a), ea);
    check({name, " B"}, int'(fwd_b), eb);
    @(posedge clk);
    #1;
    check({name, " ex_count"}, int'(ex_cnt), ecx);
    check({name, " mem_count"}, int'(mem_cnt), ecm);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset ex_count", int'(ex_cnt), 0);
    check("reset mem_count", int'(mem_cnt), 0);
    rst = 1'b0;
    model_on = 1'b1;

    //      name         rs1 rs2 erd ewe wrd wwe  A  B  ex mem
    step("no hazard",      1,  2,  3, 1,  4, 1,  0, 0, 0, 0);
    step("ex rs1",         5,  6,  5, 1,  0, 0,  2, 0, 1, 0);
    step("mem rs2",        0,  8,  7, 0,  8, 1,  0, 1, 1, 1);
    step("both ex",        9,  9,  9, 1, 10, 1,  2, 2, 2, 1);
    step("ex priority",    9,  9,  9, 1,  9, 1,  2, 2, 3, 1);
    step("mixed",         11, 12, 12, 1, 11, 1,  1, 2, 4, 2);
    step("both mem",      11, 11, 12, 1, 11, 1,  1, 1, 4, 3);
    step("x0 rd",          0,  0,  0, 1,  0, 1,  0, 0, 4, 3);
    step("regwrite off",  13, 14, 13, 0, 14, 0,  0, 0, 4, 3);

    // Selects stay live during reset while the counters clear.
    rst = 1'b1;
    step("in reset",       5,  6,  5, 1,  6, 1,  2, 1, 0, 0);
    rst = 1'b0;

    // Hold an EX and a MEM forward long enough to pass the counter ceiling.
    set_in(5, 6, 5, 1'b1, 6, 1'b1);
    repeat ((1 << CW) + 2) @(posedge clk);
    #1;
    check("sat ex_count", int'(ex_cnt), 15);
    check("sat mem_count", int'(mem_cnt), 15);
    check("sat A", int'(fwd_a), 2);
    check("sat B", int'(fwd_b), 1);

    @(negedge clk);
    #1;
    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_forwarding_unit

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- RISC-V 5-stage pipeline data-hazard forwarding unit, located in the EX stage.
- Compares the ID/EX source register indices against the destination indices of the instructions in EX/MEM and MEM/WB.
- Produces 2-bit mux selects for the two ALU operand muxes. Selects are purely combinational, same-cycle.
- Also maintains clocked, saturating forwarding-event counters for performance/debug observation.

Parameters:
- REG_ADDR_W, 5, register index width (32 architectural registers).
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  system clock; counters update on rising edge.
- rst  input  1  synchronous, active-high reset.
- ID_EX_Rs1  input  REG_ADDR_W  rs1 index of the instruction in EX.
- ID_EX_Rs2  input  REG_ADDR_W  rs2 index of the instruction in EX.
- EX_MEM_Rd  input  REG_ADDR_W  rd index of the instruction in MEM.
- MEM_WB_Rd  input  REG_ADDR_W  rd index of the instruction in WB.
- EX_MEM_regWrite  input  1  instruction in MEM writes the register file.
- MEM_WB_regWrite  input  1  instruction in WB writes the register file.
- Forward_A  output  2  operand A select.
- Forward_B  output  2  operand B select.
- fwd_ex_count  output  CNT_W  number of cycles with at least one EX/MEM forward.
- fwd_mem_count  output  CNT_W  number of cycles with at least one MEM/WB forward (and no EX/MEM forward on that operand).

Behaviour:
- Select encoding, shared by A and B:
  - 2'b00 = register-file value from ID/EX.
  - 2'b10 = EX/MEM ALU result.
  - 2'b01 = MEM/WB write-back value.
  - 2'b11 is never produced.
- ex_hit_X = EX_MEM_regWrite && (EX_MEM_Rd != 0) && (EX_MEM_Rd == ID_EX_RsX).
- mem_hit_X = MEM_WB_regWrite && (MEM_WB_Rd != 0) && (MEM_WB_Rd == ID_EX_RsX).
- Forward_X = 2'b10 if ex_hit_X; else 2'b01 if mem_hit_X; else 2'b00.
- Priority: EX/MEM wins over MEM/WB when both match, because it holds the most recent value.
- x0 rule: Rd == 0 never forwards, even with regWrite = 1. A source index of 0 therefore always yields 00.
- A and B are evaluated independently. Both may select the same stage, e.g. Rs1 == Rs2 == EX_MEM_Rd gives 10/10.
- regWrite = 0 suppresses matching for that stage regardless of index equality.
- Forward_A/Forward_B are pure combinational functions of the inputs:
  - no latency, no register;
  - unaffected by clk and rst, including during reset;
  - valid within the same delta/cycle the inputs settle.
- Counters, evaluated per clk rising edge:
  - rst = 1: both counters load 0. Reset takes precedence over counting.
  - Otherwise fwd_ex_count increments by 1 if (Forward_A == 10 || Forward_B == 10).
  - Otherwise fwd_mem_count increments by 1 if (Forward_A == 01 || Forward_B == 01).
  - Both counters may increment in the same cycle, e.g. A = 01 and B = 10.
  - Counters saturate at all-ones and do not wrap.
  - Counter reset value: 0.

Decomposition:
- Shared pipeline package holds:
  - localparams FWD_REGFILE = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10;
  - REG_ADDR_W.
- Natural sub-module: fwd_select. Instantiated twice, once per operand. Inputs: rs, both rd/regWrite pairs. Output: 2-bit select.
- Counters live in the top module.

Test Plan:
- No hazard: Rs1=1, Rs2=2, EX_MEM_Rd=3, MEM_WB_Rd=4, both regWrite=1 -> A=00, B=00; counters unchanged after clk.
- EX hazard on rs1: Rs1=5, Rs2=6, EX_MEM_Rd=5 (regWrite=1), MEM_WB_Rd=0 (regWrite=0) -> A=10, B=00; fwd_ex_count +1 next edge.
- MEM hazard on rs2: Rs1=0, Rs2=8, EX_MEM_Rd=7 (regWrite=0), MEM_WB_Rd=8 (regWrite=1) -> A=00, B=01.
- Both on EX with priority: Rs1=Rs2=9, EX_MEM_Rd=9, MEM_WB_Rd=10, both regWrite=1 -> A=10, B=10. Then set MEM_WB_Rd=9 -> still 10/10 (EX priority).
- Mixed/both MEM: Rs1=11, Rs2=12, EX_MEM_Rd=12, MEM_WB_Rd=11 -> A=01, B=10, both counters +1. Then Rs2=11 -> A=01, B=01.
- x0 and reset/saturation:
  - EX_MEM_Rd=0 = Rs1=0 with regWrite=1 -> A=00.
  - rst=1 for one edge -> counters 0 while Forward outputs still track inputs.
  - Hold a forwarding condition for 2^CNT_W+2 cycles (use CNT_W=4) -> counter stays at 4'hF.
